// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART definitions for the receive and transmit paths.
// Receiver FSM state encoding, default oversample ratio, parity helper.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } spart_state_t;

    localparam int SPART_OVERSAMPLE = 16;

    // Parity bit that makes the frame's one-count even (odd=0) or odd (odd=1)
    function automatic logic parity_bit(
        input logic [8:0] data,
        input int         width,
        input logic       odd
    );
        logic p;
        p = odd;
        for (int i = 0; i < 9; i++) begin
            if (i < width) p ^= data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: first-word-fall-through FIFO with occupancy count.
// Reports a dropped push when full and not popped in the same cycle.
module spart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rda,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("spart_fifo: DEPTH must be a power of two >= 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign rda     = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & rda;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign rd_data = rda ? mem[rd_ptr] : '0;

    // Storage only changes on an accepted push, so it needs no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap at DEPTH; occupancy tracks push/pop independently
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: oversampling SPART receiver feeding a FWFT receive FIFO.
// Parity checking is built in when SPART_RX_PARITY_EN is defined.
module spart_rx_fifo
    import spart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int OVERSAMPLE = SPART_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            baud_en,
    input  logic                            rxd,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rda,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            frame_err,
    output logic                            overrun,
    output logic                            parity_err,
    input  logic                            clr_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

`ifdef SPART_RX_PARITY_EN
    localparam spart_state_t AFTER_DATA = PARITY;
`else
    localparam spart_state_t AFTER_DATA = STOP;
`endif

    if (DATA_W < 5 || DATA_W > 9) begin : g_chk_w
        $error("spart_rx_fifo: DATA_W must be 5..9");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("spart_rx_fifo: OVERSAMPLE must be even and >= 4");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
        $error("spart_rx_fifo: PARITY_ODD must be 0 or 1");
    end

    logic [1:0]        sync_q;
    logic              rxd_s;
    spart_state_t      state_q;
    spart_state_t      state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] shreg_q;
    logic              samp;
    logic              shift_en;
    logic              push;
    logic              frm_set;
    logic              drop;
    logic              par_pend_q;

    // Two-flop synchroniser; idle-high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rxd};
    end

    assign rxd_s = sync_q[1];

    // Sample point: mid start bit in START, one full bit later elsewhere
    assign samp = baud_en &&
                  ((state_q == START) ? (cnt_q == HALF_M1)
                                      : (state_q != IDLE && cnt_q == FULL_M1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rxd_s) state_d = START;
            START:   if (samp) state_d = rxd_s ? IDLE : DATA;
            DATA:    if (samp && bit_q == LAST_BIT) state_d = AFTER_DATA;
`ifdef SPART_RX_PARITY_EN
            PARITY:  if (samp) state_d = STOP;
`endif
            STOP:    if (samp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: per-sample strobes for shift, push and error events
    always_comb begin
        shift_en = 1'b0;
        push     = 1'b0;
        frm_set  = 1'b0;
        if (samp) begin
            unique case (state_q)
                DATA: shift_en = 1'b1;
                STOP: begin
                    push    = rxd_s & ~par_pend_q;
                    frm_set = ~rxd_s;
                end
                default: ;
            endcase
        end
    end

    // Tick counter is held at zero while idle and restarts at each sample
    always_ff @(posedge clk) begin
        if (rst)                cnt_q <= '0;
        else if (state_q == IDLE) cnt_q <= '0;
        else if (baud_en)       cnt_q <= samp ? '0 : cnt_q + 1'b1;
    end

    // Data bit index, restarted for every frame in START
    always_ff @(posedge clk) begin
        if (rst)                   bit_q <= '0;
        else if (state_q == START) bit_q <= '0;
        else if (shift_en)         bit_q <= bit_q + 1'b1;
    end

    // LSB-first deserialiser; the final sample lands the LSB in bit 0
    always_ff @(posedge clk) begin
        if (rst)           shreg_q <= '0;
        else if (shift_en) shreg_q <= {rxd_s, shreg_q[DATA_W-1:1]};
    end

`ifdef SPART_RX_PARITY_EN
    logic par_set;

    assign par_set = samp && (state_q == STOP) && rxd_s && par_pend_q;

    // Hold a parity mismatch until the stop bit decides the frame's fate
    always_ff @(posedge clk) begin
        if (rst)
            par_pend_q <= 1'b0;
        else if (state_q == START)
            par_pend_q <= 1'b0;
        else if (samp && state_q == PARITY)
            par_pend_q <= (rxd_s != parity_bit(9'(shreg_q), DATA_W,
                                               (PARITY_ODD != 0)));
    end

    // Sticky parity flag; a new mismatch wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= (parity_err & ~clr_err) | par_set;
    end
`else
    assign par_pend_q = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Sticky frame/overrun flags; a new error wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err & ~clr_err) | frm_set;
            overrun   <= (overrun & ~clr_err) | drop;
        end
    end

    spart_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (shreg_q),
        .pop     (rd_en),
        .rd_data (rd_data),
        .rda     (rda),
        .full    (full),
        .count   (count),
        .drop    (drop)
    );

endmodule

// File: tb/tb_spart_rx_fifo.sv
// tb_spart_rx_fifo: directed frames into spart_rx_fifo, 16x oversample,
// baud_en every 4 clocks; expected values are fixed by hand.
`timescale 1ns/1ps
module tb_spart_rx_fifo;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int OVERSAMPLE = 16;
    localparam int PARITY_ODD = 0;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

`ifdef SPART_RX_PARITY_EN
    localparam int NB = DATA_W + 3;
`else
    localparam int NB = DATA_W + 2;
`endif

    logic              CLOCK_50;
    logic              rst;
    logic              baud_en;
    logic              rxd;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rda;
    logic              full;
    logic [CW-1:0]     count;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    int n_chk  = 0;
    int n_fail = 0;

    spart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (CLOCK_50),
        .rst        (rst),
        .baud_en    (baud_en),
        .rxd        (rxd),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rda        (rda),
        .full       (full),
        .count      (count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .clr_err    (clr_err)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic pop);
        baud_en = 1'b1;
        rd_en   = pop;
        @(negedge CLOCK_50);
        baud_en = 1'b0;
        rd_en   = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick(1'b0);
    endtask

`ifdef SPART_RX_PARITY_EN
    function automatic logic [10:0] mkp(input logic [7:0] d,
                                        input logic stop_v,
                                        input logic bad_par);
        logic p;
        p = (^d) ^ 1'(PARITY_ODD) ^ bad_par;
        return {stop_v, p, d, 1'b0};
    endfunction

    function automatic logic [10:0] mk(input logic [7:0] d,
                                       input logic stop_v);
        return mkp(d, stop_v, 1'b0);
    endfunction
`else
    function automatic logic [10:0] mk(input logic [7:0] d,
                                       input logic stop_v);
        return 11'({stop_v, d, 1'b0});
    endfunction
`endif

    // Stop bit released high after its mid-bit tick; optional pop on that tick
    task automatic send(input logic [10:0] bits, input logic pop_stop);
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < OVERSAMPLE; k++) begin
                if (b == NB - 1 && k > OVERSAMPLE / 2) rxd = 1'b1;
                else                                   rxd = bits[b];
                tick(pop_stop && b == NB - 1 && k == OVERSAMPLE / 2);
            end
        end
        rxd = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge CLOCK_50);
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        @(negedge CLOCK_50);
        clr_err = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        baud_en = 1'b0;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (4) @(negedge CLOCK_50);

        chk("rst_rda", 32'(rda), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_perr", 32'(parity_err), 0);
        rst = 1'b0;
        idle(4);

        send(mk(8'h48, 1'b1), 1'b0);
        idle(4);
        chk("h_rda", 32'(rda), 1);
        chk("h_data", 32'(rd_data), 32'h48);
        chk("h_count", 32'(count), 1);
        chk("h_ferr", 32'(frame_err), 0);
        chk("h_ovr", 32'(overrun), 0);
        chk("h_perr", 32'(parity_err), 0);
        pop_chk("h_pop", 8'h48);
        chk("h_empty", 32'(rda), 0);

        rd_en = 1'b1;
        @(negedge CLOCK_50);
        rd_en = 1'b0;
        chk("empty_pop_cnt", 32'(count), 0);
        chk("empty_pop_data", 32'(rd_data), 0);

        for (int i = 1; i <= 9; i++) begin
            send(mk(8'(i), 1'b1), 1'b0);
            idle(2);
        end
        chk("ovr_full", 32'(full), 1);
        chk("ovr_count", 32'(count), 8);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_ferr", 32'(frame_err), 0);
        for (int i = 1; i <= 8; i++)
            pop_chk($sformatf("ovr_pop%0d", i), 8'(i));
        chk("ovr_drained", 32'(rda), 0);
        chk("ovr_nfull", 32'(full), 0);
        clear_flags();
        chk("ovr_clr", 32'(overrun), 0);

        send(mk(8'h55, 1'b0), 1'b0);
        idle(20);
        chk("frm_flag", 32'(frame_err), 1);
        chk("frm_count", 32'(count), 0);
        chk("frm_ovr", 32'(overrun), 0);
        clear_flags();
        chk("frm_clr", 32'(frame_err), 0);

        rxd = 1'b0;
        repeat (5) tick(1'b0);
        idle(24);
        chk("gl_count", 32'(count), 0);
        chk("gl_ferr", 32'(frame_err), 0);
        chk("gl_ovr", 32'(overrun), 0);
        send(mk(8'hA7, 1'b1), 1'b0);
        idle(4);
        chk("gl_next_cnt", 32'(count), 1);
        pop_chk("gl_next_data", 8'hA7);

        for (int i = 0; i < 8; i++) begin
            send(mk(8'(8'h10 + i), 1'b1), 1'b0);
            idle(2);
        end
        chk("sim_pre_cnt", 32'(count), 8);
        send(mk(8'h18, 1'b1), 1'b1);
        idle(4);
        chk("sim_count", 32'(count), 8);
        chk("sim_full", 32'(full), 1);
        chk("sim_ovr", 32'(overrun), 0);
        for (int i = 0; i < 8; i++)
            pop_chk($sformatf("sim_pop%0d", i), 8'(8'h11 + i));
        chk("sim_drained", 32'(count), 0);

`ifdef SPART_RX_PARITY_EN
        send(mkp(8'h48, 1'b1, 1'b1), 1'b0);
        idle(4);
        chk("par_bad_flag", 32'(parity_err), 1);
        chk("par_bad_cnt", 32'(count), 0);
        send(mkp(8'h48, 1'b1, 1'b0), 1'b0);
        idle(4);
        chk("par_ok_cnt", 32'(count), 1);
        pop_chk("par_ok_data", 8'h48);
        clear_flags();
        chk("par_clr", 32'(parity_err), 0);
`endif

        send(mk(8'h3C, 1'b1), 1'b0);
        idle(2);
        chk("mid_pre_cnt", 32'(count), 1);
        rxd = 1'b0;
        repeat (20) tick(1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(count), 0);
        chk("mid_rst_rda", 32'(rda), 0);
        chk("mid_rst_data", 32'(rd_data), 0);
        idle(4);
        send(mk(8'hA5, 1'b1), 1'b0);
        idle(4);
        chk("mid_next_cnt", 32'(count), 1);
        pop_chk("mid_next_data", 8'hA5);
        chk("mid_ferr", 32'(frame_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
